// File: rtl/relu_layer_sequencer.sv
// rtl/relu_layer_sequencer.sv - feeds a layer's chunks one at a time through a shared ReLU bank
module relu_layer_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int OUTPUT_NODES = 32,
    parameter int CNT_W        = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               start_i,
    input  logic [CNT_W-1:0]                   num_chunks_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [CNT_W-1:0]                   chunk_idx_o,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] in_data_i,
    output logic                               relu_en_o,
    output logic [DATA_WIDTH*OUTPUT_NODES-1:0] relu_in_o,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] relu_out_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [DATA_WIDTH*OUTPUT_NODES-1:0] out_data_o,
    output logic                               out_last_o
);

    localparam int VEC_W = DATA_WIDTH * OUTPUT_NODES;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        FIRE    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             in_ready_q, in_ready_d;
    logic             relu_en_q, relu_en_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [CNT_W-1:0] chunk_idx_q, chunk_idx_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [VEC_W-1:0] relu_in_q, relu_in_d;
    logic [VEC_W-1:0] out_data_q, out_data_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            relu_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            chunk_idx_q <= '0;
            total_q     <= '0;
            relu_in_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            relu_en_q   <= relu_en_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            chunk_idx_q <= chunk_idx_d;
            total_q     <= total_d;
            relu_in_q   <= relu_in_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        in_ready_d  = in_ready_q;
        relu_en_d   = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        chunk_idx_d = chunk_idx_q;
        total_d     = total_q;
        relu_in_d   = relu_in_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_chunks_i != '0) begin
                        total_d     = num_chunks_i;
                        chunk_idx_d = '0;
                        busy_d      = 1'b1;
                        in_ready_d  = 1'b1;
                        state_d     = WAIT_IN;
                    end else begin
                        // An empty layer completes immediately without touching the bank
                        done_d = 1'b1;
                    end
                end
            end
            WAIT_IN: begin
                if (in_valid_i && in_ready_q) begin
                    relu_in_d  = in_data_i;
                    relu_en_d  = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = FIRE;
                end
            end
            FIRE: begin
                // The bank captured relu_in on the negedge inside this cycle
                out_data_d  = relu_out_i;
                out_valid_d = 1'b1;
                out_last_d  = (chunk_idx_q == total_q - ONE);
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        chunk_idx_d = '0;
                        state_d     = IDLE;
                    end else begin
                        chunk_idx_d = chunk_idx_q + ONE;
                        in_ready_d  = 1'b1;
                        state_d     = WAIT_IN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign chunk_idx_o = chunk_idx_q;
    assign in_ready_o  = in_ready_q;
    assign relu_en_o   = relu_en_q;
    assign relu_in_o   = relu_in_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// tb/tb_relu_layer_sequencer.sv - directed bench for relu_layer_sequencer with a negedge ReLU bank model
module tb_relu_layer_sequencer;

    localparam int DW = 16;
    localparam int NODES = 32;
    localparam int CW = 8;
    localparam int VW = DW * NODES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_chunks;
    logic          busy;
    logic          done;
    logic [CW-1:0] chunk_idx;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          relu_en;
    logic [VW-1:0] relu_in;
    logic [VW-1:0] relu_out = '0;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic          out_last;

    int nvec = 0;
    int nerr = 0;

    relu_layer_sequencer #(.DATA_WIDTH(DW), .OUTPUT_NODES(NODES), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .num_chunks_i (num_chunks),
        .busy_o       (busy),
        .done_o       (done),
        .chunk_idx_o  (chunk_idx),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .relu_en_o    (relu_en),
        .relu_in_o    (relu_in),
        .relu_out_i   (relu_out),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = '0;
        for (int k = 0; k < NODES; k++)
            if (!v[k*DW + DW-1]) r[k*DW +: DW] = v[k*DW +: DW];
        return r;
    endfunction

    // Shared bank stand-in: registers the clamp on the falling edge while enabled
    always @(negedge clk) if (relu_en) relu_out <= relu_vec(relu_in);

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int k = 0; k < NODES; k++) r[k*DW +: DW] = 16'($urandom);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        start = 1'b1;
        num_chunks = n;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [VW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("feed_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("feed_fire", relu_en, 1);
    endtask

    logic [VW-1:0] d, e, da, ea, db, eb;
    logic [VW-1:0] q[$];
    int nout, nin, ndone, nlast;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_chunks = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) step();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_relu_en", relu_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_chunk_idx", chunk_idx, 0);
        chk("rst_relu_in", relu_in, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        step();

        // Async reset landing in the FIRE cycle
        do_start(2);
        chk("t1_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data = {VW{1'b1}};
        step();
        chk("t1_fire", relu_en, 1);
        chk("t1_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_async_relu_en", relu_en, 0);
        chk("t1_async_out_valid", out_valid, 0);
        chk("t1_async_busy", busy, 0);
        chk("t1_async_done", done, 0);
        chk("t1_async_relu_in", relu_in, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("t1_post_in_ready", in_ready, 0);
        chk("t1_post_busy", busy, 0);
        chk("t1_post_out_valid", out_valid, 0);
        step();

        // Three chunks, downstream always ready
        out_ready = 1'b1;
        do_start(3);
        chk("t2_busy_start", busy, 1);
        for (int c = 0; c < 3; c++) begin
            d = '0;
            d[15:0]  = 16'h8005;
            d[31:16] = 16'h1234;
            d[47:32] = 16'(c);
            d[VW-1 -: 16] = 16'hFFFF;
            e = '0;
            e[31:16] = 16'h1234;
            e[47:32] = 16'(c);
            feed(d);
            chk("t2_fire_no_valid", out_valid, 0);
            step();
            chk("t2_out_valid", out_valid, 1);
            chk("t2_out_data", out_data, e);
            chk("t2_out_last", out_last, (c == 2) ? 1 : 0);
            chk("t2_in_ready_hold", in_ready, 0);
            chk("t2_busy_hold", busy, 1);
            step();
            if (c < 2) begin
                chk("t2_done_mid", done, 0);
                chk("t2_chunk_idx", chunk_idx, c + 1);
                chk("t2_in_ready_next", in_ready, 1);
            end else begin
                chk("t2_done", done, 1);
                chk("t2_busy_done", busy, 0);
                chk("t2_chunk_idx_clr", chunk_idx, 0);
            end
        end
        out_ready = 1'b0;
        step();
        chk("t2_done_pulse", done, 0);

        // Single chunk with in_valid already up at start
        d = '0;
        d[15:0]  = 16'h4321;
        d[31:16] = 16'hC000;
        e = '0;
        e[15:0]  = 16'h4321;
        in_valid = 1'b1;
        in_data = d;
        do_start(1);
        chk("t3_in_ready", in_ready, 1);
        chk("t3_idle_not_consumed", relu_en, 0);
        step();
        in_valid = 1'b0;
        chk("t3_fire", relu_en, 1);
        chk("t3_in_ready_low", in_ready, 0);
        chk("t3_latency1", out_valid, 0);
        step();
        chk("t3_latency2", out_valid, 1);
        chk("t3_last", out_last, 1);
        chk("t3_data", out_data, e);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_out_valid_clr", out_valid, 0);
        step();
        chk("t3_done_clr", done, 0);

        // Downstream stall in HOLD
        da = '0;
        da[15:0]  = 16'h7FFF;
        da[31:16] = 16'h8000;
        da[47:32] = 16'hFFFF;
        da[63:48] = 16'h0001;
        ea = '0;
        ea[15:0]  = 16'h7FFF;
        ea[63:48] = 16'h0001;
        db = '0;
        db[15:0]  = 16'h00AA;
        db[95:80] = 16'h9999;
        eb = '0;
        eb[15:0]  = 16'h00AA;
        do_start(2);
        feed(da);
        step();
        in_valid = 1'b1;
        in_data = db;
        for (int i = 0; i < 10; i++) begin
            chk("t4_valid_hold", out_valid, 1);
            chk("t4_data_hold", out_data, ea);
            chk("t4_last_hold", out_last, 0);
            chk("t4_in_ready_hold", in_ready, 0);
            chk("t4_no_consume", relu_en, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_release_valid", out_valid, 0);
        chk("t4_release_ready", in_ready, 1);
        chk("t4_release_idx", chunk_idx, 1);
        step();
        in_valid = 1'b0;
        chk("t4_b_fire", relu_en, 1);
        step();
        chk("t4_b_data", out_data, eb);
        chk("t4_b_last", out_last, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_done", done, 1);
        step();

        // Empty layer, then start while busy
        do_start(0);
        chk("t5_done_empty", done, 1);
        chk("t5_busy_empty", busy, 0);
        chk("t5_relu_en_empty", relu_en, 0);
        chk("t5_in_ready_empty", in_ready, 0);
        step();
        chk("t5_done_clr", done, 0);
        chk("t5_busy_still", busy, 0);
        do_start(2);
        start = 1'b1;
        num_chunks = 8'd5;
        feed(da);
        start = 1'b0;
        step();
        chk("t5_last0", out_last, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_idx1", chunk_idx, 1);
        feed(db);
        step();
        chk("t5_last1", out_last, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_done", done, 1);
        step();

        // Maximum-length layer with random stalls on both sides
        nout = 0;
        nin = 0;
        ndone = 0;
        nlast = 0;
        do_start(8'd255);
        for (int cyc = 0; cyc < 20000 && nout < 255; cyc++) begin
            if (done) ndone++;
            chk("t6_ready_valid_excl", in_ready & out_valid, 0);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                chk("t6_data", out_data, (q.size() != 0) ? q[0] : '0);
                chk("t6_last", out_last, (nout == 254) ? 1 : 0);
                chk("t6_idx", chunk_idx, nout);
                if (out_last) nlast++;
                if (q.size() != 0) void'(q.pop_front());
                nout++;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data = rand_vec();
            if (in_valid && in_ready) begin
                q.push_back(relu_vec(in_data));
                nin++;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t6_nout", nout, 255);
        repeat (3) begin
            if (done) ndone++;
            step();
        end
        chk("t6_nin", nin, 255);
        chk("t6_ndone", ndone, 1);
        chk("t6_nlast", nlast, 1);
        chk("t6_busy_end", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
